// File: rtl/pmd901_pkg.sv
// pmd901_pkg: shared types and ramp arithmetic for the PMD901 speed scheduler.
package pmd901_pkg;
  typedef enum logic [1:0] {PARKED = 2'd0, START = 2'd1, RUN = 2'd2, STOP = 2'd3} state_e;
  typedef logic signed [15:0] speed_t;
  // Widened to 17 bits so a full-scale reversal cannot overflow the distance.
  function automatic speed_t step_toward(speed_t cur, speed_t tgt, logic [15:0] stp);
    logic signed [16:0] d;
    logic [16:0] mag;
    d = $signed({tgt[15], tgt}) - $signed({cur[15], cur});
    mag = d[16] ? $unsigned(-d) : $unsigned(d);
    return (mag <= {1'b0, stp}) ? tgt : d[16] ? speed_t'(cur - speed_t'(stp)) : speed_t'(cur + speed_t'(stp));
  endfunction
  function automatic speed_t clamp(speed_t v, logic [15:0] lim);
    speed_t m;
    m = speed_t'(lim);
    return (v > m) ? m : (v < -m) ? -m : v;
  endfunction
endpackage

// File: rtl/pmd901_speed_sched_tick_gen.sv
// pmd901_tick_gen: free-running period counter with synchronous restart and 1-cycle tick.
module pmd901_tick_gen #(
  parameter logic [11:0] PERIOD = 12'd2048
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart_i,
  output logic tick_o
);
  logic [11:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == PERIOD - 12'd1;
  assign cnt_d = (restart_i || tick_o) ? '0 : cnt_q + 12'd1;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pmd901_speed_sched.sv
// pmd901_speed_sched: host target handshake, rate-limited speed ramp and enable/park sequencing
// for the PMD901 SPI writer.
module pmd901_speed_sched
  import pmd901_pkg::*;
#(
  parameter logic [11:0] UPDATE_PERIOD = 12'd2048,
  parameter logic [15:0] MAX_STEP      = 16'd64,
  parameter logic [15:0] STOP_STEP     = 16'd256,
  parameter logic [15:0] MAX_SPEED     = 16'd16000,
  parameter logic [7:0]  ENABLE_DELAY  = 8'd100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        host_req,
  input  logic [15:0] host_speed,
  output logic        host_ack,
  output logic        host_rej,
  input  logic        safe_stop,
  input  logic        fault,
  output logic [15:0] wdata,
  output logic        we,
  output logic        dev_enable,
  output logic [1:0]  state_o
);
  state_e state_q, state_d;
  speed_t target_q, target_d, current_q, current_d, wdata_q, wdata_d, req_speed, stepped;
  logic ack_q, ack_d, rej_q, rej_d, we_q, we_d;
  logic take, stop_cond, restart, tick, adv;
  logic [7:0] en_cnt_q, en_cnt_d;

  pmd901_tick_gen #(.PERIOD(UPDATE_PERIOD)) u_tick (
    .clk       (clk),
    .rstn      (rstn),
    .restart_i (restart),
    .tick_o    (tick)
  );

  always_comb begin
    stop_cond = safe_stop | fault;
    take = host_req & ~(ack_q | rej_q);
    rej_d = take & (stop_cond | (state_q == STOP));
    ack_d = take & ~rej_d;
    req_speed = clamp(speed_t'(host_speed), MAX_SPEED);
    stepped = step_toward(current_q, target_q, (state_q == STOP) ? STOP_STEP : MAX_STEP);
    adv = tick && ((state_q == RUN && !stop_cond) || state_q == STOP);
    state_d = state_q;
    case (state_q)
      PARKED:  state_d = (ack_d && req_speed != '0) ? START : PARKED;
      START:   state_d = stop_cond ? STOP : (en_cnt_q == ENABLE_DELAY - 8'd1) ? RUN : START;
      // A target accepted on the parking tick keeps the ramp alive instead of being stranded.
      RUN:     state_d = stop_cond ? STOP
                       : (tick && current_q == '0 && target_q == '0 && !ack_d) ? PARKED : RUN;
      default: state_d = (tick && current_q == '0) ? PARKED : STOP;
    endcase
    restart = state_d != state_q;
    target_d = (state_d == STOP) ? '0 : ack_d ? req_speed : target_q;
    current_d = (state_q == PARKED) ? '0 : adv ? stepped : current_q;
    we_d = adv && stepped != current_q;
    wdata_d = we_d ? stepped : wdata_q;
    en_cnt_d = restart ? '0 : en_cnt_q + 8'(state_q == START);
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q   <= PARKED;
      target_q  <= '0;
      current_q <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      ack_q     <= 1'b0;
      rej_q     <= 1'b0;
      en_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      current_q <= current_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      ack_q     <= ack_d;
      rej_q     <= rej_d;
      en_cnt_q  <= en_cnt_d;
    end

  assign host_ack   = ack_q;
  assign host_rej   = rej_q;
  assign wdata      = wdata_q;
  assign we         = we_q;
  assign dev_enable = state_q != PARKED;
  assign state_o    = state_q;
endmodule

// File: tb/tb_pmd901_speed_sched.sv
// tb_pmd901_speed_sched: directed sequence with a write scoreboard; expected wdata values
// are queued when a target is requested and popped on each we pulse.
module tb_pmd901_speed_sched;
  logic clk = 1'b0, rstn = 1'b0, host_req = 1'b0, safe_stop = 1'b0, fault = 1'b0;
  logic [15:0] host_speed = '0;
  logic host_ack, host_rej, we, dev_enable;
  logic [15:0] wdata;
  logic [1:0] state_o;
  int n_vec = 0, n_err = 0, cyc = 0, last_we = 0;

  typedef struct {int val; int gap;} exp_t;
  exp_t sb[$];

  pmd901_speed_sched #(
    .UPDATE_PERIOD(12'd4), .MAX_STEP(16'd100), .STOP_STEP(16'd250),
    .MAX_SPEED(16'd1000), .ENABLE_DELAY(8'd3)
  ) dut (
    .clk(clk), .rstn(rstn), .host_req(host_req), .host_speed(host_speed),
    .host_ack(host_ack), .host_rej(host_rej), .safe_stop(safe_stop), .fault(fault),
    .wdata(wdata), .we(we), .dev_enable(dev_enable), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (rstn && we) begin
      if (sb.size() == 0) check("we_extra", we, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("wdata", $signed(wdata), e.val);
        if (e.gap != 0) check("we_gap", cyc - last_we, e.gap);
      end
      last_we = cyc;
    end

  task automatic request(input int v, input logic exp_ack, input string tag);
    @(negedge clk);
    host_req = 1'b1;
    host_speed = v[15:0];
    @(negedge clk);
    check({tag, "_ack"}, host_ack, exp_ack);
    check({tag, "_rej"}, host_rej, !exp_ack);
    host_req = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check({tag, "_drain"}, sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic push_ramp(input int from, input int to, input int stp);
    for (int v = from; (stp > 0) ? v <= to : v >= to; v += stp) sb.push_back('{v, (v == from) ? 0 : 4});
  endtask

  initial begin
    #3;
    check("rst_wdata", wdata, 0);
    check("rst_we", we, 0);
    check("rst_en", dev_enable, 0);
    check("rst_state", state_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    push_ramp(100, 300, 100);
    request(300, 1'b1, "start");
    check("start_state", state_o, 1);
    check("start_en", dev_enable, 1);
    repeat (2) @(negedge clk);
    check("start_hold", state_o, 1);
    @(negedge clk);
    check("run_state", state_o, 2);
    drain("start");
    repeat (12) @(negedge clk);
    check("start_final", $signed(wdata), 300);
    sb.push_back('{200, 0});
    push_ramp(100, -100, -100);
    sb.push_back('{-150, 4});
    request(-150, 1'b1, "reverse");
    drain("reverse");
    check("rev_en", dev_enable, 1);
    check("rev_state", state_o, 2);
    sb.push_back('{-50, 0});
    push_ramp(50, 250, 100);
    sb.push_back('{300, 4});
    request(300, 1'b1, "back");
    drain("back");
    sb.push_back('{50, 0});
    sb.push_back('{0, 4});
    @(negedge clk);
    safe_stop = 1'b1;
    host_req = 1'b1;
    host_speed = 16'd500;
    @(negedge clk);
    check("stop_rej", host_rej, 1);
    check("stop_ack", host_ack, 0);
    host_req = 1'b0;
    check("stop_state", state_o, 3);
    drain("stop");
    for (int i = 0; i < 50 && state_o != 2'd0; i++) @(negedge clk);
    check("park_state", state_o, 0);
    check("park_en", dev_enable, 0);
    request(200, 1'b0, "parked_stop");
    check("parked_hold", state_o, 0);
    safe_stop = 1'b0;
    push_ramp(100, 1000, 100);
    request(32'h7FFF, 1'b1, "clamp_hi");
    drain("clamp_hi");
    push_ramp(900, -1000, -100);
    request(32'h8000, 1'b1, "clamp_lo");
    drain("clamp_lo");
    repeat (12) @(negedge clk);
    check("clamp_final", $signed(wdata), -1000);
    push_ramp(-900, 200, 100);
    request(1000, 1'b1, "midramp");
    drain("midramp");
    #2 rstn = 1'b0;
    #1;
    check("arst_wdata", wdata, 0);
    check("arst_we", we, 0);
    check("arst_en", dev_enable, 0);
    check("arst_state", state_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    request(0, 1'b1, "zero");
    repeat (10) @(negedge clk);
    check("zero_state", state_o, 0);
    check("zero_en", dev_enable, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
